ucsbece154b_dmem_resp: RTL and testbench

- Data-memory responder: the slave end of the core's data-memory load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake, waits a programmable latency, then returns a response (read data or write acknowledge) over a second valid/ready handshake.
- Replaces the zero-latency dmem so the pipeline's stall logic is exercised.
- Word storage lives in a DATA array indexed by word offset from BASE, so the bench can inspect memory hierarchically.

---
 rtl/ucsbece154b_dmem_resp.sv | 105 ++++++++++
 tb/tb_ucsbece154b_dmem_resp.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_dmem_resp.sv
// ucsbece154b_dmem_resp: latency-programmable data-memory responder with valid/ready request and response channels
// Optional build macro DMEM_MISALIGN_CHECK_EN: when defined, a non-word-aligned address is treated as a fault.
module ucsbece154b_dmem_resp #(
  parameter logic [31:0] BASE    = 32'h10000000,
  parameter int          DEPTH   = 64,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int         IW     = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [32:0] LO    = {1'b0, BASE};
  localparam logic [32:0] HI    = {1'b0, BASE} + 33'(4 * DEPTH);

  logic [31:0]   DATA [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          accept, access, acc_we, in_range, misaligned, fault;
  logic [31:0]   acc_addr, acc_wdata;
  logic [3:0]    acc_wstrb;
  logic [IW-1:0] idx;

  assign accept = reset && state_q == S_IDLE && req_valid;
  // With a single-cycle latency the access happens on the accept edge itself, straight from the request bus.
  assign access    = (LATENCY == 1) ? accept : (reset && state_q == S_WAIT && cnt_q == '0);
  assign acc_we    = (LATENCY == 1) ? req_we    : we_q;
  assign acc_addr  = (LATENCY == 1) ? req_addr  : addr_q;
  assign acc_wdata = (LATENCY == 1) ? req_wdata : wdata_q;
  assign acc_wstrb = (LATENCY == 1) ? req_wstrb : wstrb_q;
  // 33-bit compare so a window near the top of the address space cannot wrap.
  assign in_range  = {1'b0, acc_addr} >= LO && {1'b0, acc_addr} < HI;
  assign idx       = IW'((acc_addr - BASE) >> 2);
`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = acc_addr[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif
  assign fault      = !in_range || misaligned;

  assign req_ready  = reset && state_q == S_IDLE;
  assign resp_valid = state_q == S_RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state: accept moves to WAIT (or RESP), counter expiry moves to RESP, response handshake returns to IDLE.
  always_comb begin
    state_d = accept ? ((LATENCY == 1) ? S_RESP : S_WAIT) :
              access ? S_RESP :
              (state_q == S_RESP && resp_ready) ? S_IDLE : state_q;
    cnt_d   = accept ? LAT_M1 : (state_q == S_WAIT && cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
    rdata_d = access ? ((fault || acc_we) ? '0 : DATA[idx]) : rdata_q;
    err_d   = access ? fault : err_q;
  end

  // Control and response registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

  // Word storage is not reset; stores write only the enabled byte lanes of an in-range word.
  always_ff @(posedge clk) begin
    if (access && acc_we && !fault)
      for (int b = 0; b < 4; b++)
        if (acc_wstrb[b]) DATA[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_ucsbece154b_dmem_resp.sv
// tb_ucsbece154b_dmem_resp: directed self-checking bench for the data-memory responder
module tb_ucsbece154b_dmem_resp;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  int          errs = 0;
  int          checks = 0;

  ucsbece154b_dmem_resp dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: present request, wait for accept, count cycles to response, handshake it.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      if (lat == 0) check("busy_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] snap [64];
  int          nd;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10000070;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
    end
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end

    xact(1'b1, 32'h10000070, 32'h0BEEF000, 4'hF, rd, er, lat);
    check("st70_lat", 32'(lat), 32'd2);
    check("st70_err", 32'(er), 32'd0);
    check("st70_rdata", rd, 32'd0);
    check("st70_mem", dut.DATA[28], 32'h0BEEF000);
    xact(1'b0, 32'h10000070, 32'h0, 4'h0, rd, er, lat);
    check("ld70_lat", 32'(lat), 32'd2);
    check("ld70_err", 32'(er), 32'd0);
    check("ld70_rdata", rd, 32'h0BEEF000);

    xact(1'b1, 32'h1000006C, 32'h00000019, 4'hF, rd, er, lat);
    xact(1'b1, 32'h1000006C, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    xact(1'b0, 32'h1000006C, 32'h0, 4'h0, rd, er, lat);
    check("ld6c_strb", rd, 32'h00BB00DD);
    xact(1'b1, 32'h1000006C, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    check("st6c_nostrb_mem", dut.DATA[27], 32'h00BB00DD);

    xact(1'b1, 32'h10000000, 32'hCAFE0001, 4'hF, rd, er, lat);
    check("first_word", dut.DATA[0], 32'hCAFE0001);
    xact(1'b1, 32'h100000FC, 32'h600DF00D, 4'hF, rd, er, lat);
    xact(1'b0, 32'h100000FC, 32'h0, 4'h0, rd, er, lat);
    check("last_word_rdata", rd, 32'h600DF00D);
    check("last_word_err", 32'(er), 32'd0);

    for (int i = 0; i < 64; i++) snap[i] = dut.DATA[i];
    xact(1'b0, 32'h10000100, 32'h0, 4'h0, rd, er, lat);
    check("oor_hi_err", 32'(er), 32'd1);
    check("oor_hi_rdata", rd, 32'd0);
    check("oor_hi_lat", 32'(lat), 32'd2);
    xact(1'b1, 32'h0FFFFFFC, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("oor_lo_err", 32'(er), 32'd1);
    check("oor_lo_rdata", rd, 32'd0);
    nd = 0;
    for (int i = 0; i < 64; i++) if (dut.DATA[i] !== snap[i]) nd++;
    check("oor_mem_unchanged", 32'(nd), 32'd0);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10000070;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h1000006C;
    lat = 0;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    check("bp_lat", 32'(lat), 32'd2);
    repeat (5) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'h0BEEF000);
      check("bp_err", 32'(resp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_drop", 32'(resp_valid), 32'd0);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_second_accepted", 32'(req_ready), 32'd0);
    lat = 0;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    check("bp2_lat", 32'(lat), 32'd2);
    check("bp2_rdata", resp_rdata, 32'h00BB00DD);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    xact(1'b1, 32'h10000028, 32'h5A5A5A5A, 4'hF, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10000028; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_idle", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    check("abort_mem", dut.DATA[10], 32'h5A5A5A5A);

    xact(1'b1, 32'h10000060, 32'h11111111, 4'hF, rd, er, lat);
    xact(1'b1, 32'h10000062, 32'h12345678, 4'hF, rd, er, lat);
    check("mis_lat", 32'(lat), 32'd2);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("mis_err", 32'(er), 32'd1);
    check("mis_mem", dut.DATA[24], 32'h11111111);
`else
    check("mis_err", 32'(er), 32'd0);
    check("mis_mem", dut.DATA[24], 32'h12345678);
    xact(1'b0, 32'h10000063, 32'h0, 4'h0, rd, er, lat);
    check("mis_ld_rdata", rd, 32'h12345678);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
